// File: rtl/dcache_wb_axi.sv
// Write-back engine: buffers one evicted dirty cache line and drains it to memory
// as a single AXI4 INCR write burst (AW, then W beats, then B).
module dcache_wb_axi #(
    parameter int          WORDS_PER_LINE = 8,
    parameter logic [3:0]  AXI_ID         = 4'd1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wb_req,
    input  logic [31:0]                 wb_addr,
    input  logic [32*WORDS_PER_LINE-1:0] wb_data,
    output logic                        wb_ready,
    output logic                        wb_done,
    output logic                        wb_err,
    output logic [3:0]                  awid,
    output logic [31:0]                 awaddr,
    output logic [7:0]                  awlen,
    output logic [2:0]                  awsize,
    output logic [1:0]                  awburst,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [31:0]                 wdata,
    output logic [3:0]                  wstrb,
    output logic                        wlast,
    output logic                        wvalid,
    input  logic                        wready,
    input  logic [3:0]                  bid,
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready
);

    localparam int BEAT_W = $clog2(WORDS_PER_LINE);
    localparam int OFF_W  = BEAT_W + 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               wlast_q, wlast_d;
    logic               bready_q, bready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               accept;
    logic [31:0]        line_q [WORDS_PER_LINE];

    // bid and bresp[0] carry no information we act on; the line offset is discarded.
    logic unused_inputs;
    assign unused_inputs = ^{bid, bresp[0], wb_addr[OFF_W-1:0]};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: if (wb_req) begin
                accept  = 1'b1;
                addr_d  = {wb_addr[31:OFF_W], {OFF_W{1'b0}}};
                beat_d  = '0;
                state_d = ADDR;
            end
            ADDR: if (awready) state_d = DATA;
            DATA: if (wready) begin
                if (wlast_q) state_d = RESP;
                else         beat_d  = beat_q + 1'b1;
            end
            RESP: if (bvalid) begin
                done_d  = 1'b1;
                err_d   = bresp[1];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Channel outputs are registered, so they are decoded from the next state.
        awvalid_d = (state_d == ADDR);
        wvalid_d  = (state_d == DATA);
        bready_d  = (state_d == RESP);
        wlast_d   = (state_d == DATA) && (beat_d == LAST_BEAT);
        if (state_d == DATA) wdata_d = line_q[beat_d];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            beat_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            beat_q    <= beat_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // The line is copied on acceptance so the cache RAM can be refilled right away.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < WORDS_PER_LINE; i++) line_q[i] <= wb_data[32*i +: 32];
        end
    end

    assign wb_ready = (state_q == IDLE);
    assign wb_done  = done_q;
    assign wb_err   = err_q;
    assign awid     = AXI_ID;
    assign awaddr   = addr_q;
    assign awlen    = 8'(WORDS_PER_LINE - 1);
    assign awsize   = 3'b010;
    assign awburst  = 2'b01;
    assign awvalid  = awvalid_q;
    assign wdata    = wdata_q;
    assign wstrb    = 4'hF;
    assign wlast    = wlast_q;
    assign wvalid   = wvalid_q;
    assign bready   = bready_q;

endmodule

// File: doc/dcache_wb_axi.md
# dcache_wb_axi

Write-back engine for the data cache. It takes one evicted dirty line, already read out of the cache line storage together with its reconstructed line address, and drains it to memory as a single AXI4 INCR write burst. It sits between the DCache controller's eviction path and the AXI write channels of the memory interface, and is the write-to-memory counterpart of the line refill path.

## Interface

- `WORDS_PER_LINE`, 8: 32-bit words per cache line; must be a power of two, 2..16.
- `AXI_ID`, 4'd1: constant driven on `awid`.
- `clk`  in  1  — single clock; all logic on rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `wb_req`  in  1  — eviction request; `wb_addr`/`wb_data` are valid while high.
- `wb_addr`  in  32  — byte address of the line; low log2(WORDS_PER_LINE)+2 bits are ignored.
- `wb_data`  in  32*WORDS_PER_LINE  — line data; word i = `wb_data[32*i +: 32]`.
- `wb_ready`  out  1  — engine idle, request accepted when `wb_req && wb_ready`.
- `wb_done`  out  1  — one-cycle pulse when the write response is received.
- `wb_err`  out  1  — valid with `wb_done`; equals `bresp[1]`.
- `awid` out 4, `awaddr` out 32, `awlen` out 8, `awsize` out 3, `awburst` out 2, `awvalid` out 1, `awready` in 1 — AXI write address channel.
- `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1 — AXI write data channel.
- `bid` in 4, `bresp` in 2, `bvalid` in 1, `bready` out 1 — AXI write response channel.

## Operation

- The FSM has four states: IDLE, ADDR, DATA, RESP.
- **IDLE**: `wb_ready`=1. On `wb_req`, the block:
  - captures the line into an internal buffer;
  - captures the aligned address (offset bits forced to 0);
  - clears the beat counter;
  - moves to ADDR.
- **ADDR**: `awvalid`=1 with constant fields:
  - `awaddr` = captured aligned address;
  - `awlen` = WORDS_PER_LINE-1;
  - `awsize` = 3'b010;
  - `awburst` = 2'b01;
  - `awid` = AXI_ID.
  - On `awready`, move to DATA. Fields are held stable while `awvalid && !awready`.
- **DATA**: `wvalid`=1, `wdata` = buffer word[beat], `wstrb` = 4'hF, `wlast` = (beat == WORDS_PER_LINE-1).
  - On `wready`, beat increments.
  - On the `wlast` handshake, move to RESP.
- **RESP**: `bready`=1. On `bvalid`, pulse `wb_done`, set `wb_err` = `bresp[1]`, and return to IDLE.
  - `bid` is not checked.
  - OKAY and EXOKAY both report no error.
- Address and data are strictly sequential: no W beat is issued before the AW handshake.
- At most one line is in flight. `wb_req` is ignored outside IDLE.
- The beat counter is log2(WORDS_PER_LINE) bits wide and never wraps within a burst.
- Since `wb_data` is buffered, the cache RAM line may be overwritten by the refill from the cycle after acceptance.

## Timing

- Reset values:
  - state = IDLE, `wb_ready`=1;
  - `awvalid`, `wvalid`, `wlast`, `bready`, `wb_done`, `wb_err` = 0;
  - `awaddr`, `wdata` = 0.
  - `awlen`, `awsize`, `awburst`, `wstrb`, `awid` are constants.
- All outputs other than `wb_ready` are registered. `wb_ready` is a decode of the state register.
- Request accepted at edge T → `awvalid`=1 from T+1.
- AW handshake at edge A → `wvalid`=1 with word 0 from A+1.
- With `wready` held high, beats occupy consecutive cycles. The last beat is at A+WORDS_PER_LINE with `wlast`=1.
- Last W handshake at edge L → `bready`=1 from L+1.
- `bvalid` at edge R → `wb_done`=1 for the cycle after R, and `wb_ready`=1 in that same cycle.
  - A new request may therefore be accepted at R+1.
- Minimum request-to-done time is WORDS_PER_LINE+3 cycles when all ready/valid inputs are high.
- `wvalid` low periods: none. Once asserted, `wvalid` stays high until `wlast` completes.
- Asynchronous `reset` mid-burst:
  - the FSM returns immediately to IDLE and all valid/ready outputs drop;
  - the in-flight line is discarded;
  - only used at system reset.

## Test plan

- **Single line, ideal slave:** `wb_addr`=0x0000_1234, words 0x1000_0000+i, all ready/`bvalid` high.
  - Expect `awaddr`=0x0000_1220, `awlen`=7, `awsize`=2, `awburst`=1.
  - Expect 8 beats 0x1000_0000..0x1000_0007 with `wlast` only on the 8th beat.
  - Expect `wb_done` 11 cycles after acceptance, `wb_err`=0.
- **Backpressure:**
  - Hold `awready` low 5 cycles → `awvalid` and `awaddr` stay stable and no `wvalid` appears.
  - Toggle `wready` 1-0-1-0 → each word is held until its handshake, with no skipped or duplicated beat.
- **Error response:** `bresp`=2'b10 → `wb_done`=1 and `wb_err`=1 for exactly one cycle, then `wb_ready`=1.
- **Back-to-back lines:** `wb_req` held high with line A, switched to line B after the first `wb_done` → two complete bursts. Line B's `awvalid` rises the cycle after acceptance at R+1.
- **Mid-burst reset:**
  - Assert `reset` after beat 3 → `wvalid`, `awvalid`, `bready` are 0 immediately and `wb_ready`=1.
  - After release, a new request produces a clean burst starting at word 0.
- **Request while busy:** pulse `wb_req` with different data during DATA → ignored; the current burst data is unchanged.
